// File: rtl/mux_pkg.sv
// Shared constants for the full-parallel data multiplexer family.
// Also holds a helper that checks whether a select width is supported.
package mux_pkg;

    localparam int MUX_SEL2         = 2;
    localparam int MUX_SEL3         = 3;
    localparam int MUX_SEL4         = 4;
    localparam int MUX_DEFAULT_SIZE = 8;
    localparam int MUX_MAX_INPUTS   = 16;

    function automatic bit mux_sel_width_ok(input int width);
        return (width >= MUX_SEL2) && (width <= MUX_SEL4);
    endfunction

endpackage : mux_pkg

// File: rtl/mux_full_parallel_core.sv
// Combinational N:1 selector with no priority encoding.
// A select holding X or Z yields zero on the output.
module mux_full_parallel_core
    import mux_pkg::*;
#(
    parameter int SIZE      = MUX_DEFAULT_SIZE,
    parameter int SEL_WIDTH = MUX_SEL4
) (
    input  logic [SEL_WIDTH-1:0] sel_i,
    input  logic [SIZE-1:0]      data_i [MUX_MAX_INPUTS],
    output logic [SIZE-1:0]      data_o
);

    logic [3:0] sel_ext;

    // Widen the select so that one case table serves every legal width.
    // Inputs that are never reachable at narrow widths are tied to zero by the parent.
    assign sel_ext = 4'(sel_i);

    always_comb begin
        data_o = '0;
        case (sel_ext)
            4'd0:    data_o = data_i[0];
            4'd1:    data_o = data_i[1];
            4'd2:    data_o = data_i[2];
            4'd3:    data_o = data_i[3];
            4'd4:    data_o = data_i[4];
            4'd5:    data_o = data_i[5];
            4'd6:    data_o = data_i[6];
            4'd7:    data_o = data_i[7];
            4'd8:    data_o = data_i[8];
            4'd9:    data_o = data_i[9];
            4'd10:   data_o = data_i[10];
            4'd11:   data_o = data_i[11];
            4'd12:   data_o = data_i[12];
            4'd13:   data_o = data_i[13];
            4'd14:   data_o = data_i[14];
            4'd15:   data_o = data_i[15];
            default: data_o = '0;
        endcase
    end

endmodule : mux_full_parallel_core

// File: rtl/mux_full_parallel.sv
// Full-parallel N:1 multiplexer with a combinational output and a registered copy.
// This file also contains the fixed 2/3/4-bit select wrappers used by the MMU read path.
module mux_full_parallel
    import mux_pkg::*;
#(
    parameter int SIZE      = MUX_DEFAULT_SIZE,
    parameter int SEL_WIDTH = MUX_SEL4
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic [SEL_WIDTH-1:0] Sel,
    input  logic [SIZE-1:0]      I0,
    input  logic [SIZE-1:0]      I1,
    input  logic [SIZE-1:0]      I2,
    input  logic [SIZE-1:0]      I3,
    input  logic [SIZE-1:0]      I4,
    input  logic [SIZE-1:0]      I5,
    input  logic [SIZE-1:0]      I6,
    input  logic [SIZE-1:0]      I7,
    input  logic [SIZE-1:0]      I8,
    input  logic [SIZE-1:0]      I9,
    input  logic [SIZE-1:0]      I10,
    input  logic [SIZE-1:0]      I11,
    input  logic [SIZE-1:0]      I12,
    input  logic [SIZE-1:0]      I13,
    input  logic [SIZE-1:0]      I14,
    input  logic [SIZE-1:0]      I15,
    output logic [SIZE-1:0]      O,
    output logic [SIZE-1:0]      oQ
);

    if (!mux_sel_width_ok(SEL_WIDTH)) begin : g_bad_sel_width
        $fatal(1, "mux_full_parallel: SEL_WIDTH %0d is outside 2..4", SEL_WIDTH);
    end

    logic [SIZE-1:0] data_in [MUX_MAX_INPUTS];
    logic [SIZE-1:0] oq_d;
    logic [SIZE-1:0] oq_q;

    assign data_in = '{I0, I1, I2, I3, I4, I5, I6, I7,
                       I8, I9, I10, I11, I12, I13, I14, I15};

    mux_full_parallel_core #(
        .SIZE      (SIZE),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_core (
        .sel_i  (Sel),
        .data_i (data_in),
        .data_o (O)
    );

    assign oq_d = O;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oq_q <= '0;
        end else begin
            oq_q <= oq_d;
        end
    end

    assign oQ = oq_q;

endmodule : mux_full_parallel

// 2-bit select variant: four active inputs.
module mux_full_parallel_sel2
    import mux_pkg::*;
#(
    parameter int SIZE = MUX_DEFAULT_SIZE
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic [1:0]      Sel,
    input  logic [SIZE-1:0] I0,
    input  logic [SIZE-1:0] I1,
    input  logic [SIZE-1:0] I2,
    input  logic [SIZE-1:0] I3,
    output logic [SIZE-1:0] O,
    output logic [SIZE-1:0] oQ
);

    localparam logic [SIZE-1:0] TIE0 = '0;

    mux_full_parallel #(
        .SIZE      (SIZE),
        .SEL_WIDTH (MUX_SEL2)
    ) u_mux (
        .iClock (iClock), .iReset (iReset), .Sel (Sel),
        .I0 (I0),   .I1 (I1),   .I2 (I2),   .I3 (I3),
        .I4 (TIE0), .I5 (TIE0), .I6 (TIE0), .I7 (TIE0),
        .I8 (TIE0), .I9 (TIE0), .I10 (TIE0), .I11 (TIE0),
        .I12 (TIE0), .I13 (TIE0), .I14 (TIE0), .I15 (TIE0),
        .O (O), .oQ (oQ)
    );

endmodule : mux_full_parallel_sel2

// 3-bit select variant: eight active inputs.
module mux_full_parallel_sel3
    import mux_pkg::*;
#(
    parameter int SIZE = MUX_DEFAULT_SIZE
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic [2:0]      Sel,
    input  logic [SIZE-1:0] I0,
    input  logic [SIZE-1:0] I1,
    input  logic [SIZE-1:0] I2,
    input  logic [SIZE-1:0] I3,
    input  logic [SIZE-1:0] I4,
    input  logic [SIZE-1:0] I5,
    input  logic [SIZE-1:0] I6,
    input  logic [SIZE-1:0] I7,
    output logic [SIZE-1:0] O,
    output logic [SIZE-1:0] oQ
);

    localparam logic [SIZE-1:0] TIE0 = '0;

    mux_full_parallel #(
        .SIZE      (SIZE),
        .SEL_WIDTH (MUX_SEL3)
    ) u_mux (
        .iClock (iClock), .iReset (iReset), .Sel (Sel),
        .I0 (I0), .I1 (I1), .I2 (I2), .I3 (I3),
        .I4 (I4), .I5 (I5), .I6 (I6), .I7 (I7),
        .I8 (TIE0), .I9 (TIE0), .I10 (TIE0), .I11 (TIE0),
        .I12 (TIE0), .I13 (TIE0), .I14 (TIE0), .I15 (TIE0),
        .O (O), .oQ (oQ)
    );

endmodule : mux_full_parallel_sel3

// 4-bit select variant: all sixteen inputs active.
module mux_full_parallel_sel4
    import mux_pkg::*;
#(
    parameter int SIZE = MUX_DEFAULT_SIZE
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic [3:0]      Sel,
    input  logic [SIZE-1:0] I0,
    input  logic [SIZE-1:0] I1,
    input  logic [SIZE-1:0] I2,
    input  logic [SIZE-1:0] I3,
    input  logic [SIZE-1:0] I4,
    input  logic [SIZE-1:0] I5,
    input  logic [SIZE-1:0] I6,
    input  logic [SIZE-1:0] I7,
    input  logic [SIZE-1:0] I8,
    input  logic [SIZE-1:0] I9,
    input  logic [SIZE-1:0] I10,
    input  logic [SIZE-1:0] I11,
    input  logic [SIZE-1:0] I12,
    input  logic [SIZE-1:0] I13,
    input  logic [SIZE-1:0] I14,
    input  logic [SIZE-1:0] I15,
    output logic [SIZE-1:0] O,
    output logic [SIZE-1:0] oQ
);

    mux_full_parallel #(
        .SIZE      (SIZE),
        .SEL_WIDTH (MUX_SEL4)
    ) u_mux (
        .iClock (iClock), .iReset (iReset), .Sel (Sel),
        .I0 (I0), .I1 (I1), .I2 (I2), .I3 (I3),
        .I4 (I4), .I5 (I5), .I6 (I6), .I7 (I7),
        .I8 (I8), .I9 (I9), .I10 (I10), .I11 (I11),
        .I12 (I12), .I13 (I13), .I14 (I14), .I15 (I15),
        .O (O), .oQ (oQ)
    );

endmodule : mux_full_parallel_sel4

// File: tb/tb_mux_full_parallel.sv
// Self-checking bench for mux_full_parallel and its fixed-width wrappers.
// It uses directed vector tables, hand-written reset sequences, and random stimulus compared against an array model.
module tb_mux_full_parallel;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sel4;
    logic [2:0] sel3;
    logic [1:0] sel2;
    logic [7:0] d4 [16];
    logic [7:0] d3 [8];
    logic [7:0] d2 [4];
    logic [7:0] o4, q4, ow4, qw4, o3, q3, o2, q2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        logic [3:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    mux_full_parallel #(.SIZE(8), .SEL_WIDTH(4)) dut4 (
        .iClock (clk), .iReset (rst), .Sel (sel4),
        .I0 (d4[0]), .I1 (d4[1]), .I2 (d4[2]), .I3 (d4[3]),
        .I4 (d4[4]), .I5 (d4[5]), .I6 (d4[6]), .I7 (d4[7]),
        .I8 (d4[8]), .I9 (d4[9]), .I10 (d4[10]), .I11 (d4[11]),
        .I12 (d4[12]), .I13 (d4[13]), .I14 (d4[14]), .I15 (d4[15]),
        .O (o4), .oQ (q4)
    );

    mux_full_parallel_sel4 #(.SIZE(8)) dutw4 (
        .iClock (clk), .iReset (rst), .Sel (sel4),
        .I0 (d4[0]), .I1 (d4[1]), .I2 (d4[2]), .I3 (d4[3]),
        .I4 (d4[4]), .I5 (d4[5]), .I6 (d4[6]), .I7 (d4[7]),
        .I8 (d4[8]), .I9 (d4[9]), .I10 (d4[10]), .I11 (d4[11]),
        .I12 (d4[12]), .I13 (d4[13]), .I14 (d4[14]), .I15 (d4[15]),
        .O (ow4), .oQ (qw4)
    );

    mux_full_parallel_sel3 #(.SIZE(8)) dut3 (
        .iClock (clk), .iReset (rst), .Sel (sel3),
        .I0 (d3[0]), .I1 (d3[1]), .I2 (d3[2]), .I3 (d3[3]),
        .I4 (d3[4]), .I5 (d3[5]), .I6 (d3[6]), .I7 (d3[7]),
        .O (o3), .oQ (q3)
    );

    mux_full_parallel_sel2 #(.SIZE(8)) dut2 (
        .iClock (clk), .iReset (rst), .Sel (sel2),
        .I0 (d2[0]), .I1 (d2[1]), .I2 (d2[2]), .I3 (d2[3]),
        .O (o2), .oQ (q2)
    );

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp, input bit quiet);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end else if (!quiet) begin
            $display("ok   %s actual=%02h", name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] act;
        logic [7:0] exp;
        logic [7:0] exp3;

        rst  = 1'b1;
        sel4 = '0;
        sel3 = '0;
        sel2 = '0;
        for (int i = 0; i < 16; i++) d4[i] = 8'(i * 3 + 1);
        d4[4]  = 8'h90;
        d4[15] = 8'hA5;
        d3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
        d2 = '{8'hC3, 8'hC3, 8'h7E, 8'h7E};

        vecs[0]  = '{4, 4'h4, 8'h90};
        vecs[1]  = '{4, 4'hF, 8'hA5};
        vecs[2]  = '{3, 4'd0, 8'h11};
        vecs[3]  = '{3, 4'd1, 8'h22};
        vecs[4]  = '{3, 4'd2, 8'h33};
        vecs[5]  = '{3, 4'd3, 8'h44};
        vecs[6]  = '{3, 4'd4, 8'h55};
        vecs[7]  = '{3, 4'd5, 8'h00};
        vecs[8]  = '{3, 4'd6, 8'h00};
        vecs[9]  = '{3, 4'd7, 8'h00};
        vecs[10] = '{2, 4'd2, 8'h7E};
        vecs[11] = '{2, 4'd3, 8'h7E};
        vecs[12] = '{2, 4'd0, 8'hC3};
        vecs[13] = '{2, 4'd1, 8'hC3};

        repeat (2) @(posedge clk);
        #1;
        check("reset_q4", q4, 8'h00, 1'b0);
        check("reset_q3", q3, 8'h00, 1'b0);
        check("reset_q2", q2, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            case (vecs[v].dut)
                4:       sel4 = vecs[v].sel;
                3:       sel3 = vecs[v].sel[2:0];
                default: sel2 = vecs[v].sel[1:0];
            endcase
            #1;
            case (vecs[v].dut)
                4:       act = o4;
                3:       act = o3;
                default: act = o2;
            endcase
            check($sformatf("table%0d_sel%0d_w%0d", v, vecs[v].sel, vecs[v].dut),
                  act, vecs[v].exp, 1'b0);
        end

        // Registered path, then an asynchronous reset between edges.
        @(negedge clk);
        sel4 = 4'h4;
        #1 check("o4_sel4", o4, 8'h90, 1'b0);
        @(posedge clk);
        #1 check("q4_after_edge", q4, 8'h90, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("q4_async_reset", q4, 8'h00, 1'b0);
        check("o4_during_reset", o4, 8'h90, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("q4_no_edge_yet", q4, 8'h00, 1'b0);
        @(posedge clk);
        #1 check("q4_first_edge_after_reset", q4, 8'h90, 1'b0);

        // Change select and data together.
        @(negedge clk);
        sel4  = 4'h7;
        d4[7] = 8'h3C;
        #1 check("o4_simultaneous", o4, 8'h3C, 1'b0);
        @(posedge clk);
        #1 check("q4_simultaneous", q4, 8'h3C, 1'b0);

        // Unknown select: I0 is zero, so either the default branch or I0 reads zero.
        @(negedge clk);
        d4[0] = 8'h00;
        sel4  = 4'bxxxx;
        #1 check("o4_sel_x", o4, 8'h00, 1'b0);
        sel4 = 4'h0;

        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            sel4 = 4'($urandom);
            sel3 = 3'($urandom);
            for (int j = 0; j < 16; j++) d4[j] = 8'($urandom);
            for (int j = 0; j < 8; j++)  d3[j] = 8'($urandom);
            exp  = d4[sel4];
            exp3 = d3[sel3];
            #1;
            check($sformatf("rand%0d_o4", n), o4, exp, 1'b1);
            check($sformatf("rand%0d_ow4", n), ow4, exp, 1'b1);
            check($sformatf("rand%0d_o3", n), o3, exp3, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_q4", n), q4, exp, 1'b1);
            check($sformatf("rand%0d_qw4", n), qw4, exp, 1'b1);
            check($sformatf("rand%0d_q3", n), q3, exp3, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_full_parallel
